// File: rtl/core_alu_issue.sv
// Issue sequencer between decode and the core ALU/register file: accept, read, execute, write back.
// Optional condition flags are enabled by defining CORE_ALU_ISSUE_FLAGS_EN.
module core_alu_issue #(
  parameter int unsigned W    = 16,
  parameter int unsigned REGS = 16,
  localparam int unsigned RA  = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_valid,
  output logic          dec_ready,
  input  logic [2:0]    dec_op,
  input  logic [RA-1:0] dec_rd,
  input  logic [RA-1:0] dec_ra,
  input  logic [RA-1:0] dec_rb,
  input  logic          dec_use_imm,
  input  logic [W-1:0]  dec_imm,
  output logic [RA-1:0] rf_ra_addr,
  output logic [RA-1:0] rf_rb_addr,
  input  logic [W-1:0]  rf_ra_data,
  input  logic [W-1:0]  rf_rb_data,
  output logic          alu_start,
  output logic [2:0]    alu_op,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  input  logic [W-1:0]  alu_q,
  output logic          rf_we,
  output logic [RA-1:0] rf_waddr,
  output logic [W-1:0]  rf_wdata,
  output logic          err,
  output logic          busy
`ifdef CORE_ALU_ISSUE_FLAGS_EN
  ,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_c,
  output logic          flag_v
`endif
);

  localparam logic [2:0] OP_ADD = 3'd5;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t        state;
  logic [2:0]    op_q;
  logic [RA-1:0] rd_q;
  logic          use_imm_q;
  logic [W-1:0]  imm_q;
  logic [W-1:0]  a_hold;
  logic [W-1:0]  b_hold;

  // Read data only arrives in EXEC, so operands are steered straight from the
  // register file then and held afterwards until the next execute.
  always_comb begin
    alu_a = a_hold;
    alu_b = b_hold;
    if (state == EXEC) begin
      alu_a = rf_ra_data;
      alu_b = use_imm_q ? imm_q : rf_rb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dec_ready  <= 1'b1;
      busy       <= 1'b0;
      alu_start  <= 1'b0;
      rf_we      <= 1'b0;
      err        <= 1'b0;
      alu_op     <= 3'd0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      rf_ra_addr <= '0;
      rf_rb_addr <= '0;
      op_q       <= 3'd0;
      rd_q       <= '0;
      use_imm_q  <= 1'b0;
      imm_q      <= '0;
      a_hold     <= '0;
      b_hold     <= '0;
    end else begin
      alu_start <= 1'b0;
      rf_we     <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (dec_valid && dec_ready) begin
            op_q      <= dec_op;
            rd_q      <= dec_rd;
            use_imm_q <= dec_use_imm;
            imm_q     <= dec_imm;
            if (dec_op == OP_RSV) begin
              err <= 1'b1;
            end else begin
              state      <= READ;
              rf_ra_addr <= dec_ra;
              rf_rb_addr <= dec_rb;
              dec_ready  <= 1'b0;
              busy       <= 1'b1;
            end
          end
        end
        READ: begin
          state     <= EXEC;
          alu_start <= 1'b1;
          alu_op    <= op_q;
        end
        EXEC: begin
          state    <= WB;
          a_hold   <= alu_a;
          b_hold   <= alu_b;
          rf_we    <= 1'b1;
          rf_waddr <= rd_q;
          rf_wdata <= alu_q;
        end
        WB: begin
          state     <= IDLE;
          dec_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          dec_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef CORE_ALU_ISSUE_FLAGS_EN
  logic [W:0] sum_x;
  logic [W:0] dif_x;

  // Carry and overflow come from our own add/subtract of the executed operands.
  always_comb begin
    sum_x = {1'b0, alu_a} + {1'b0, alu_b};
    dif_x = {1'b0, alu_a} + {1'b0, ~alu_b} + (W + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (state == EXEC) begin
      flag_z <= (alu_q == '0);
      flag_n <= alu_q[W-1];
      case (op_q)
        OP_ADD: begin
          flag_c <= sum_x[W];
          flag_v <= (alu_a[W-1] == alu_b[W-1]) && (sum_x[W-1] != alu_a[W-1]);
        end
        OP_SUB: begin
          flag_c <= dif_x[W];
          flag_v <= (alu_a[W-1] != alu_b[W-1]) && (dif_x[W-1] != alu_a[W-1]);
        end
        default: begin
          flag_c <= 1'b0;
          flag_v <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_core_alu_issue.sv
// Scoreboard bench for core_alu_issue with a register file and ALU environment.
module tb_core_alu_issue;
  localparam int unsigned W    = 16;
  localparam int unsigned REGS = 16;
  localparam int unsigned RA   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dec_valid = 1'b0;
  logic          dec_ready;
  logic [2:0]    dec_op = 3'd0;
  logic [RA-1:0] dec_rd = '0, dec_ra = '0, dec_rb = '0;
  logic          dec_use_imm = 1'b0;
  logic [W-1:0]  dec_imm = '0;
  logic [RA-1:0] rf_ra_addr, rf_rb_addr;
  logic [W-1:0]  rf_ra_data, rf_rb_data;
  logic          alu_start;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_a, alu_b, alu_q;
  logic          rf_we;
  logic [RA-1:0] rf_waddr;
  logic [W-1:0]  rf_wdata;
  logic          err, busy;
`ifdef CORE_ALU_ISSUE_FLAGS_EN
  logic          flag_z, flag_n, flag_c, flag_v;
`endif

  core_alu_issue #(.W(W), .REGS(REGS)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
    .dec_rd(dec_rd), .dec_ra(dec_ra), .dec_rb(dec_rb),
    .dec_use_imm(dec_use_imm), .dec_imm(dec_imm),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_q(alu_q),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .err(err), .busy(busy)
`ifdef CORE_ALU_ISSUE_FLAGS_EN
    , .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = (32'(b) >= W) ? '0 : a << b;
      3'd4: r = (32'(b) >= W) ? '0 : a >> b;
      3'd5: r = a + b;
      3'd6: r = a - b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Environment: synchronous-read register file with a preload port, and the ALU.
  logic [W-1:0]  rf [REGS];
  logic          pl_we = 1'b0;
  logic [RA-1:0] pl_addr = '0;
  logic [W-1:0]  pl_data = '0;
  always @(posedge clk) begin
    rf_ra_data <= rf[rf_ra_addr];
    rf_rb_data <= rf[rf_rb_addr];
    if (pl_we) rf[pl_addr] <= pl_data;
    if (rf_we) rf[rf_waddr] <= rf_wdata;
  end
  always_comb alu_q = ref_alu(alu_op, alu_a, alu_b);

  typedef struct {
    logic          is_err;
    int            hs;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [RA-1:0] rd;
    logic [W-1:0]  wd;
    logic [3:0]    flg;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] mregs [REGS];
  int           vectors = 0;
  int           miscompares = 0;
  logic         mon_en = 1'b0;
  logic [2:0]   hop = 3'd0;
  logic [W-1:0] ha = '0, hb = '0;
  logic [3:0]   cur_flg = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every cycle, compare whatever the DUT presents against the queue front.
  always @(negedge clk) begin
    logic exp_rdy;
    if (mon_en) begin
      exp_rdy = !(q.size() != 0 && !q[0].is_err && cyc >= q[0].hs + 1 && cyc <= q[0].hs + 3);
      chk("dec_ready", 32'(dec_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(!exp_rdy));
      if (alu_start) begin
        if (q.size() == 0 || q[0].is_err) chk("unexpected_alu_start", 32'(1), 32'(0));
        else begin
          chk("start_cycle", 32'(cyc), 32'(q[0].hs + 2));
          chk("alu_op", 32'(alu_op), 32'(q[0].op));
          chk("alu_a", 32'(alu_a), 32'(q[0].a));
          chk("alu_b", 32'(alu_b), 32'(q[0].b));
          hop = q[0].op; ha = q[0].a; hb = q[0].b;
        end
      end else begin
        chk("alu_op_hold", 32'(alu_op), 32'(hop));
        chk("alu_a_hold", 32'(alu_a), 32'(ha));
        chk("alu_b_hold", 32'(alu_b), 32'(hb));
      end
      if (rf_we) begin
        if (q.size() == 0 || q[0].is_err) chk("unexpected_rf_we", 32'(1), 32'(0));
        else begin
          chk("wb_cycle", 32'(cyc), 32'(q[0].hs + 3));
          chk("rf_waddr", 32'(rf_waddr), 32'(q[0].rd));
          chk("rf_wdata", 32'(rf_wdata), 32'(q[0].wd));
          cur_flg = q[0].flg;
          void'(q.pop_front());
        end
      end
      if (err) begin
        if (q.size() == 0 || !q[0].is_err) chk("unexpected_err", 32'(1), 32'(0));
        else begin
          chk("err_cycle", 32'(cyc), 32'(q[0].hs + 1));
          void'(q.pop_front());
        end
      end
`ifdef CORE_ALU_ISSUE_FLAGS_EN
      chk("flags_znc_v", 32'({flag_z, flag_n, flag_c, flag_v}), 32'(cur_flg));
`endif
      if (q.size() != 0 && cyc > q[0].hs + (q[0].is_err ? 1 : 3)) begin
        chk("missing_output", 32'(0), 32'(1));
        void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input int r, input logic [W-1:0] v);
    pl_we = 1'b1; pl_addr = RA'(r); pl_data = v;
    mregs[r] = v;
    tick();
    pl_we = 1'b0;
  endtask

  // Offer one instruction, wait for the handshake, then record the expected outcome.
  task automatic issue(input logic [2:0] op, input int rd, input int ra, input int rb,
                       input logic ui, input logic [W-1:0] imm, output int hs);
    exp_t e;
    int n;
    int sa, sb;
    dec_valid = 1'b1; dec_op = op; dec_rd = RA'(rd); dec_ra = RA'(ra); dec_rb = RA'(rb);
    dec_use_imm = ui; dec_imm = imm;
    n = 0;
    while (!dec_ready && n < 64) begin tick(); n++; end
    if (!dec_ready) begin
      chk("handshake_timeout", 32'(0), 32'(1));
      hs = -1;
      return;
    end
    hs = cyc;
    e.is_err = (op == 3'd7);
    e.hs = hs; e.op = op; e.rd = RA'(rd);
    e.a = mregs[ra];
    e.b = ui ? imm : mregs[rb];
    e.wd = ref_alu(op, e.a, e.b);
    sa = int'($signed(e.a)); sb = int'($signed(e.b));
    e.flg[3] = (e.wd == '0);
    e.flg[2] = e.wd[W-1];
    e.flg[1] = 1'b0; e.flg[0] = 1'b0;
    if (op == 3'd5) begin
      e.flg[1] = (32'(e.a) + 32'(e.b)) >= (32'(1) << W);
      e.flg[0] = (sa + sb) > 32767 || (sa + sb) < -32768;
    end else if (op == 3'd6) begin
      e.flg[1] = e.a >= e.b;
      e.flg[0] = (sa - sb) > 32767 || (sa - sb) < -32768;
    end
    q.push_back(e);
    if (!e.is_err) mregs[rd] = e.wd;
    tick();
  endtask

  task automatic idle(input int n);
    dec_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int hs1, hs2;
    logic [W-1:0] saved;
    logic [2:0] op;
    int r;

    rst = 1'b1;
    for (int i = 0; i < int'(REGS); i++) set_reg(i, W'($urandom));
    chk("rst_dec_ready", 32'(dec_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_alu_start", 32'(alu_start), 32'(0));
    chk("rst_rf_we", 32'(rf_we), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_alu_op", 32'(alu_op), 32'(0));
    chk("rst_alu_a", 32'(alu_a), 32'(0));
    chk("rst_alu_b", 32'(alu_b), 32'(0));
    chk("rst_rf_waddr", 32'(rf_waddr), 32'(0));
    chk("rst_rf_wdata", 32'(rf_wdata), 32'(0));
    chk("rst_rf_ra_addr", 32'(rf_ra_addr), 32'(0));
    chk("rst_rf_rb_addr", 32'(rf_rb_addr), 32'(0));
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // ADD r3 = r1 + r2 -> 0x000C
    set_reg(1, 16'h0005); set_reg(2, 16'h0007);
    issue(3'd5, 3, 1, 2, 1'b0, '0, hs1);
    idle(6);
    chk("add_result_model", 32'(mregs[3]), 32'h000C);

    // SUB 0 - imm 1 -> 0xFFFF
    set_reg(1, 16'h0000);
    issue(3'd6, 4, 1, 0, 1'b1, 16'h0001, hs1);
    idle(6);

    // Shifts, including an amount equal to the width.
    set_reg(1, 16'h0001); set_reg(2, 16'h8000);
    issue(3'd3, 5, 1, 0, 1'b1, 16'd16, hs1);
    issue(3'd3, 5, 1, 0, 1'b1, 16'd4, hs1);
    issue(3'd4, 5, 2, 0, 1'b1, 16'd15, hs1);
    idle(6);

    // Reserved opcode followed immediately by AND.
    set_reg(6, 16'h00F0); set_reg(7, 16'h0FF0);
    issue(3'd7, 8, 6, 7, 1'b0, '0, hs1);
    issue(3'd0, 8, 6, 7, 1'b0, '0, hs2);
    chk("err_then_accept", 32'(hs2 - hs1), 32'(1));
    idle(6);

    // Held valid: second instruction reads the register the first one writes.
    issue(3'd5, 9, 6, 7, 1'b0, '0, hs1);
    issue(3'd5, 10, 9, 9, 1'b0, '0, hs2);
    chk("b2b_spacing", 32'(hs2 - hs1), 32'(4));
    idle(6);

    // Reset while the instruction is in EXEC.
    saved = mregs[11];
    issue(3'd1, 11, 6, 7, 1'b0, '0, hs1);
    dec_valid = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    #1;
    q.delete();
    hop = 3'd0; ha = '0; hb = '0; cur_flg = 4'd0;
    mregs[11] = saved;
    tick();
    rst = 1'b0;
    chk("post_rst_ready", 32'(dec_ready), 32'(1));
    chk("post_rst_no_start", 32'(alu_start), 32'(0));
    chk("post_rst_no_we", 32'(rf_we), 32'(0));
    idle(3);
    issue(3'd2, 12, 11, 6, 1'b0, '0, hs1);
    idle(6);

    // Randomized traffic with occasional gaps and reserved opcodes.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 15));
      op = (r < 14) ? 3'(r % 7) : 3'd7;
      issue(op, int'($urandom_range(0, REGS - 1)), int'($urandom_range(0, REGS - 1)),
            int'($urandom_range(0, REGS - 1)), 1'($urandom_range(0, 1)),
            (op == 3'd3 || op == 3'd4) ? W'($urandom_range(0, 20)) : W'($urandom), hs1);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 3)));
    end
    idle(10);
    chk("queue_drained", 32'(q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
